control_sequencer: RTL and testbench

Multi-cycle control unit that drives the CPU datapath's register-transfer strobes. Every instruction is sequenced through fetch steps T0–T2 and execute steps T3–T7. The sequencer is the bus initiator: it decides each cycle which source drives the shared bus (`*out`) and which registers latch it (`*in`). It reads the instruction register and the CON FF branch flag back from the datapath.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/control_sequencer_if.sv | 31 +++
 rtl/instr_class_decode.sv | 34 +++
 rtl/control_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states and
// instruction classes.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU_RR, CLS_ALU_IMM, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV, CLS_UNARY,
    CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP,
    CLS_HALT
  } instr_class_t;

  function automatic logic [4:0] get_opcode(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer (master) and the
// datapath/memory side (slave).
interface control_sequencer_if;

  logic        stop;
  logic        mem_ready;
  logic [31:0] ir;
  logic        con_ff;

  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, inportout, cout, Rout, BAout;
  logic Gra, Grb, Grc, Rin, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic outportin, CONin, IncPC;
  logic Read, Write;
  logic [4:0] alu_op;
  logic clear, run;

  modport master (
    input  stop, mem_ready, ir, con_ff,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, inportout, cout, Rout, BAout,
    output Gra, Grb, Grc, Rin, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output outportin, CONin, IncPC, Read, Write, alu_op, clear, run
  );

  modport slave (
    output stop, mem_ready, ir, con_ff,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, inportout, cout, Rout, BAout,
    input  Gra, Grb, Grc, Rin, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    input  outportin, CONin, IncPC, Read, Write, alu_op, clear, run
  );

endinterface

// File: rtl/instr_class_decode.sv
// Maps a 5-bit opcode onto the instruction class that selects an execute
// sequence; undefined opcodes fall into the NOP class.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   i_opcode,
  output instr_class_t o_class
);

  // Opcode to execute-sequence class
  always_comb begin
    o_class = CLS_NOP;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:          o_class = CLS_ALU_RR;
      OP_ADDI, OP_ANDI, OP_ORI:        o_class = CLS_ALU_IMM;
      OP_LD:                           o_class = CLS_LD;
      OP_LDI:                          o_class = CLS_LDI;
      OP_ST:                           o_class = CLS_ST;
      OP_MUL, OP_DIV:                  o_class = CLS_MULDIV;
      OP_NEG, OP_NOT:                  o_class = CLS_UNARY;
      OP_BR:                           o_class = CLS_BR;
      OP_JR:                           o_class = CLS_JR;
      OP_JAL:                          o_class = CLS_JAL;
      OP_IN:                           o_class = CLS_IN;
      OP_OUT:                          o_class = CLS_OUT;
      OP_MFHI:                         o_class = CLS_MFHI;
      OP_MFLO:                         o_class = CLS_MFLO;
      OP_HALT:                         o_class = CLS_HALT;
      default:                         o_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle sequencer: fetch T0-T2, class-specific execute T3-T7, with
// memory wait states and a stop/halt path. Strobes are Moore-decoded.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  control_sequencer_if.master io_bus
);

  state_t       r_state;
  state_t       w_next_state;
  state_t       w_retire_state;
  instr_class_t w_class;
  logic [4:0]   w_opcode;
  logic         w_unused_ir_fields;

  assign w_opcode = get_opcode(io_bus.ir);
  // Register fields are consumed by the datapath, not by the sequencer.
  assign w_unused_ir_fields = ^io_bus.ir[26:0];

  instr_class_decode u_decode (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: step sequencing, memory waits and retirement
  always_comb begin
    w_next_state = r_state;
    if (io_bus.stop) begin
      w_retire_state = ST_HALT;
    end else begin
      w_retire_state = ST_T0;
    end
    case (r_state)
      ST_RESET: w_next_state = ST_T0;
      ST_T0:    w_next_state = ST_T1;
      ST_T1: begin
        if (io_bus.mem_ready) begin
          w_next_state = ST_T2;
        end else begin
          w_next_state = ST_T1;
        end
      end
      ST_T2: begin
        case (w_class)
          CLS_HALT: w_next_state = ST_HALT;
          CLS_NOP:  w_next_state = w_retire_state;
          default:  w_next_state = ST_T3;
        endcase
      end
      ST_T3: begin
        case (w_class)
          CLS_ALU_RR, CLS_ALU_IMM, CLS_LD, CLS_LDI, CLS_ST,
          CLS_MULDIV, CLS_UNARY, CLS_BR, CLS_JAL: w_next_state = ST_T4;
          default:                                w_next_state = w_retire_state;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CLS_ALU_RR, CLS_ALU_IMM, CLS_LD, CLS_LDI, CLS_ST,
          CLS_MULDIV, CLS_BR:                     w_next_state = ST_T5;
          default:                                w_next_state = w_retire_state;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CLS_LD, CLS_ST, CLS_MULDIV, CLS_BR: w_next_state = ST_T6;
          default:                            w_next_state = w_retire_state;
        endcase
      end
      ST_T6: begin
        case (w_class)
          CLS_LD: begin
            if (io_bus.mem_ready) begin
              w_next_state = ST_T7;
            end else begin
              w_next_state = ST_T6;
            end
          end
          CLS_ST:  w_next_state = ST_T7;
          default: w_next_state = w_retire_state;
        endcase
      end
      ST_T7: begin
        case (w_class)
          CLS_ST: begin
            if (io_bus.mem_ready) begin
              w_next_state = w_retire_state;
            end else begin
              w_next_state = ST_T7;
            end
          end
          default: w_next_state = w_retire_state;
        endcase
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_RESET;
    endcase
  end

  // Strobe decode from state x instruction class
  always_comb begin
    io_bus.PCout = 1'b0;  io_bus.MDRout = 1'b0;    io_bus.Zhighout = 1'b0;
    io_bus.Zlowout = 1'b0; io_bus.HIout = 1'b0;    io_bus.LOout = 1'b0;
    io_bus.inportout = 1'b0; io_bus.cout = 1'b0;   io_bus.Rout = 1'b0;
    io_bus.BAout = 1'b0;  io_bus.Gra = 1'b0;       io_bus.Grb = 1'b0;
    io_bus.Grc = 1'b0;    io_bus.Rin = 1'b0;       io_bus.PCin = 1'b0;
    io_bus.IRin = 1'b0;   io_bus.MARin = 1'b0;     io_bus.MDRin = 1'b0;
    io_bus.Yin = 1'b0;    io_bus.Zin = 1'b0;       io_bus.HIin = 1'b0;
    io_bus.LOin = 1'b0;   io_bus.outportin = 1'b0; io_bus.CONin = 1'b0;
    io_bus.IncPC = 1'b0;  io_bus.Read = 1'b0;      io_bus.Write = 1'b0;
    io_bus.alu_op = ALU_NONE;
    io_bus.clear = (r_state == ST_RESET);
    io_bus.run = (r_state != ST_RESET) && (r_state != ST_HALT);
    case (r_state)
      ST_T0: begin
        io_bus.PCout = 1'b1; io_bus.MARin = 1'b1; io_bus.IncPC = 1'b1; io_bus.Zin = 1'b1;
      end
      ST_T1: begin
        io_bus.Zlowout = 1'b1; io_bus.PCin = 1'b1; io_bus.Read = 1'b1; io_bus.MDRin = 1'b1;
      end
      ST_T2: begin
        io_bus.MDRout = 1'b1; io_bus.IRin = 1'b1;
      end
      ST_T3: begin
        case (w_class)
          CLS_ALU_RR, CLS_ALU_IMM: begin
            io_bus.Grb = 1'b1; io_bus.Rout = 1'b1; io_bus.Yin = 1'b1;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            io_bus.Grb = 1'b1; io_bus.BAout = 1'b1; io_bus.Yin = 1'b1;
          end
          CLS_MULDIV: begin
            io_bus.Gra = 1'b1; io_bus.Rout = 1'b1; io_bus.Yin = 1'b1;
          end
          CLS_UNARY: begin
            io_bus.Grb = 1'b1; io_bus.Rout = 1'b1; io_bus.Zin = 1'b1;
            io_bus.alu_op = w_opcode;
          end
          CLS_BR: begin
            io_bus.Gra = 1'b1; io_bus.Rout = 1'b1; io_bus.CONin = 1'b1;
          end
          CLS_JR: begin
            io_bus.Gra = 1'b1; io_bus.Rout = 1'b1; io_bus.PCin = 1'b1;
          end
          CLS_JAL: begin
            io_bus.PCout = 1'b1; io_bus.Grb = 1'b1; io_bus.Rin = 1'b1;
          end
          CLS_IN: begin
            io_bus.inportout = 1'b1; io_bus.Gra = 1'b1; io_bus.Rin = 1'b1;
          end
          CLS_OUT: begin
            io_bus.Gra = 1'b1; io_bus.Rout = 1'b1; io_bus.outportin = 1'b1;
          end
          CLS_MFHI: begin
            io_bus.HIout = 1'b1; io_bus.Gra = 1'b1; io_bus.Rin = 1'b1;
          end
          CLS_MFLO: begin
            io_bus.LOout = 1'b1; io_bus.Gra = 1'b1; io_bus.Rin = 1'b1;
          end
          default: io_bus.alu_op = ALU_NONE;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CLS_ALU_RR: begin
            io_bus.Grc = 1'b1; io_bus.Rout = 1'b1; io_bus.Zin = 1'b1;
            io_bus.alu_op = w_opcode;
          end
          CLS_ALU_IMM: begin
            io_bus.cout = 1'b1; io_bus.Zin = 1'b1; io_bus.alu_op = w_opcode;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            io_bus.cout = 1'b1; io_bus.Zin = 1'b1; io_bus.alu_op = OP_ADD;
          end
          CLS_MULDIV: begin
            io_bus.Grb = 1'b1; io_bus.Rout = 1'b1; io_bus.Zin = 1'b1;
            io_bus.alu_op = w_opcode;
          end
          CLS_UNARY: begin
            io_bus.Zlowout = 1'b1; io_bus.Gra = 1'b1; io_bus.Rin = 1'b1;
          end
          CLS_BR: begin
            io_bus.PCout = 1'b1; io_bus.Yin = 1'b1;
          end
          CLS_JAL: begin
            io_bus.Gra = 1'b1; io_bus.Rout = 1'b1; io_bus.PCin = 1'b1;
          end
          default: io_bus.alu_op = ALU_NONE;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CLS_ALU_RR, CLS_ALU_IMM, CLS_LDI: begin
            io_bus.Zlowout = 1'b1; io_bus.Gra = 1'b1; io_bus.Rin = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            io_bus.Zlowout = 1'b1; io_bus.MARin = 1'b1;
          end
          CLS_MULDIV: begin
            io_bus.Zlowout = 1'b1; io_bus.LOin = 1'b1;
          end
          CLS_BR: begin
            io_bus.cout = 1'b1; io_bus.Zin = 1'b1; io_bus.alu_op = OP_ADD;
          end
          default: io_bus.alu_op = ALU_NONE;
        endcase
      end
      ST_T6: begin
        case (w_class)
          CLS_LD: begin
            io_bus.Read = 1'b1; io_bus.MDRin = 1'b1;
          end
          CLS_ST: begin
            io_bus.Gra = 1'b1; io_bus.Rout = 1'b1; io_bus.MDRin = 1'b1;
          end
          CLS_MULDIV: begin
            io_bus.Zhighout = 1'b1; io_bus.HIin = 1'b1;
          end
          // Branch is taken only when the condition latched in T3 is set.
          CLS_BR: begin
            if (io_bus.con_ff) begin
              io_bus.Zlowout = 1'b1; io_bus.PCin = 1'b1;
            end else begin
              io_bus.Zlowout = 1'b0; io_bus.PCin = 1'b0;
            end
          end
          default: io_bus.alu_op = ALU_NONE;
        endcase
      end
      ST_T7: begin
        case (w_class)
          CLS_LD: begin
            io_bus.MDRout = 1'b1; io_bus.Gra = 1'b1; io_bus.Rin = 1'b1;
          end
          CLS_ST:  io_bus.Write = 1'b1;
          default: io_bus.alu_op = ALU_NONE;
        endcase
      end
      default: io_bus.alu_op = ALU_NONE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer with hand-computed
// per-cycle strobe expectations plus reset and halt corner sequences.
module tb_control_sequencer;

  localparam logic [26:0] B_PCOUT   = 27'd1 << 0;
  localparam logic [26:0] B_MDROUT  = 27'd1 << 1;
  localparam logic [26:0] B_ZHIOUT  = 27'd1 << 2;
  localparam logic [26:0] B_ZLOOUT  = 27'd1 << 3;
  localparam logic [26:0] B_HIOUT   = 27'd1 << 4;
  localparam logic [26:0] B_LOOUT   = 27'd1 << 5;
  localparam logic [26:0] B_INPOUT  = 27'd1 << 6;
  localparam logic [26:0] B_COUT    = 27'd1 << 7;
  localparam logic [26:0] B_ROUT    = 27'd1 << 8;
  localparam logic [26:0] B_BAOUT   = 27'd1 << 9;
  localparam logic [26:0] B_GRA     = 27'd1 << 10;
  localparam logic [26:0] B_GRB     = 27'd1 << 11;
  localparam logic [26:0] B_GRC     = 27'd1 << 12;
  localparam logic [26:0] B_RIN     = 27'd1 << 13;
  localparam logic [26:0] B_PCIN    = 27'd1 << 14;
  localparam logic [26:0] B_IRIN    = 27'd1 << 15;
  localparam logic [26:0] B_MARIN   = 27'd1 << 16;
  localparam logic [26:0] B_MDRIN   = 27'd1 << 17;
  localparam logic [26:0] B_YIN     = 27'd1 << 18;
  localparam logic [26:0] B_ZIN     = 27'd1 << 19;
  localparam logic [26:0] B_HIIN    = 27'd1 << 20;
  localparam logic [26:0] B_LOIN    = 27'd1 << 21;
  localparam logic [26:0] B_OUTPIN  = 27'd1 << 22;
  localparam logic [26:0] B_CONIN   = 27'd1 << 23;
  localparam logic [26:0] B_INCPC   = 27'd1 << 24;
  localparam logic [26:0] B_READ    = 27'd1 << 25;
  localparam logic [26:0] B_WRITE   = 27'd1 << 26;

  localparam logic [26:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [26:0] F1 = B_ZLOOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [26:0] F2 = B_MDROUT | B_IRIN;
  localparam logic [26:0] NONE = 27'd0;

  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_ST    = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b01100;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_NEG   = 5'b10001;
  localparam logic [4:0] OP_BR    = 5'b10011;
  localparam logic [4:0] OP_JAL   = 5'b10101;
  localparam logic [4:0] OP_MFHI  = 5'b11000;
  localparam logic [4:0] OP_HALT  = 5'b11011;
  localparam logic [4:0] OP_UNDEF = 5'b11111;
  localparam logic [4:0] A0       = 5'b00000;

  typedef struct {
    logic [4:0]  op;
    logic        mem_ready;
    logic        stop;
    logic        con_ff;
    logic [26:0] strb;
    logic [4:0]  alu;
    logic        run;
  } vec_t;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus_if)
  );

  logic [26:0] act_strb;
  logic [33:0] act_all;
  assign act_strb = {bus_if.Write, bus_if.Read, bus_if.IncPC, bus_if.CONin, bus_if.outportin,
                     bus_if.LOin, bus_if.HIin, bus_if.Zin, bus_if.Yin, bus_if.MDRin,
                     bus_if.MARin, bus_if.IRin, bus_if.PCin, bus_if.Rin, bus_if.Grc,
                     bus_if.Grb, bus_if.Gra, bus_if.BAout, bus_if.Rout, bus_if.cout,
                     bus_if.inportout, bus_if.LOout, bus_if.HIout, bus_if.Zlowout,
                     bus_if.Zhighout, bus_if.MDRout, bus_if.PCout};
  assign act_all = {bus_if.alu_op, bus_if.clear, bus_if.run, act_strb};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [33:0] exp);
    n_tests++;
    if (act_all !== exp) begin
      n_fail++;
      $display("FAIL %s: got alu/clr/run/strb=%h, expected %h", name, act_all, exp);
    end
  endtask

  task automatic row(input logic [4:0] op, input logic mr, input logic stp,
                     input logic con, input logic [26:0] strb, input logic [4:0] alu,
                     input logic run);
    vec_t v;
    v.op = op; v.mem_ready = mr; v.stop = stp; v.con_ff = con;
    v.strb = strb; v.alu = alu; v.run = run;
    tbl.push_back(v);
  endtask

  task automatic fetch(input logic [4:0] op, input int t1_waits, input logic con);
    row(op, 1'b1, 1'b0, con, F0, A0, 1'b1);
    for (int w = 0; w < t1_waits; w++) row(op, 1'b0, 1'b0, con, F1, A0, 1'b1);
    row(op, 1'b1, 1'b0, con, F1, A0, 1'b1);
    row(op, 1'b1, 1'b0, con, F2, A0, 1'b1);
  endtask

  task automatic set_ir(input logic [4:0] op);
    bus_if.ir = {op, 4'd1, 4'd2, 4'd3, 15'd0};
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b1;
    bus_if.stop = 1'b0;
    bus_if.mem_ready = 1'b1;
    bus_if.con_ff = 1'b0;
    set_ir(OP_ADD);

    // add r1,r2,r3: T0..T5 then back to T0
    fetch(OP_ADD, 0, 1'b0);
    row(OP_ADD, 1'b1, 1'b0, 1'b0, B_GRB | B_ROUT | B_YIN, A0, 1'b1);
    row(OP_ADD, 1'b1, 1'b0, 1'b0, B_GRC | B_ROUT | B_ZIN, OP_ADD, 1'b1);
    row(OP_ADD, 1'b1, 1'b0, 1'b0, B_ZLOOUT | B_GRA | B_RIN, A0, 1'b1);
    // addi: T4 takes the constant instead of rc
    fetch(OP_ADDI, 0, 1'b0);
    row(OP_ADDI, 1'b1, 1'b0, 1'b0, B_GRB | B_ROUT | B_YIN, A0, 1'b1);
    row(OP_ADDI, 1'b1, 1'b0, 1'b0, B_COUT | B_ZIN, OP_ADDI, 1'b1);
    row(OP_ADDI, 1'b1, 1'b0, 1'b0, B_ZLOOUT | B_GRA | B_RIN, A0, 1'b1);
    // ld with one T1 wait and three T6 waits
    fetch(OP_LD, 1, 1'b0);
    row(OP_LD, 1'b1, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YIN, A0, 1'b1);
    row(OP_LD, 1'b1, 1'b0, 1'b0, B_COUT | B_ZIN, OP_ADD, 1'b1);
    row(OP_LD, 1'b1, 1'b0, 1'b0, B_ZLOOUT | B_MARIN, A0, 1'b1);
    for (int w = 0; w < 3; w++) row(OP_LD, 1'b0, 1'b0, 1'b0, B_READ | B_MDRIN, A0, 1'b1);
    row(OP_LD, 1'b1, 1'b0, 1'b0, B_READ | B_MDRIN, A0, 1'b1);
    row(OP_LD, 1'b1, 1'b0, 1'b0, B_MDROUT | B_GRA | B_RIN, A0, 1'b1);
    // br not taken, then taken
    for (int c = 0; c < 2; c++) begin
      logic con;
      con = (c == 1);
      fetch(OP_BR, 0, con);
      row(OP_BR, 1'b1, 1'b0, con, B_GRA | B_ROUT | B_CONIN, A0, 1'b1);
      row(OP_BR, 1'b1, 1'b0, con, B_PCOUT | B_YIN, A0, 1'b1);
      row(OP_BR, 1'b1, 1'b0, con, B_COUT | B_ZIN, OP_ADD, 1'b1);
      row(OP_BR, 1'b1, 1'b0, con, con ? (B_ZLOOUT | B_PCIN) : NONE, A0, 1'b1);
    end
    // undefined opcode retires after T2
    fetch(OP_UNDEF, 0, 1'b0);
    // neg
    fetch(OP_NEG, 0, 1'b0);
    row(OP_NEG, 1'b1, 1'b0, 1'b0, B_GRB | B_ROUT | B_ZIN, OP_NEG, 1'b1);
    row(OP_NEG, 1'b1, 1'b0, 1'b0, B_ZLOOUT | B_GRA | B_RIN, A0, 1'b1);
    // jal
    fetch(OP_JAL, 0, 1'b0);
    row(OP_JAL, 1'b1, 1'b0, 1'b0, B_PCOUT | B_GRB | B_RIN, A0, 1'b1);
    row(OP_JAL, 1'b1, 1'b0, 1'b0, B_GRA | B_ROUT | B_PCIN, A0, 1'b1);
    // mfhi
    fetch(OP_MFHI, 0, 1'b0);
    row(OP_MFHI, 1'b1, 1'b0, 1'b0, B_HIOUT | B_GRA | B_RIN, A0, 1'b1);
    // st with one T7 wait
    fetch(OP_ST, 0, 1'b0);
    row(OP_ST, 1'b1, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YIN, A0, 1'b1);
    row(OP_ST, 1'b1, 1'b0, 1'b0, B_COUT | B_ZIN, OP_ADD, 1'b1);
    row(OP_ST, 1'b1, 1'b0, 1'b0, B_ZLOOUT | B_MARIN, A0, 1'b1);
    row(OP_ST, 1'b1, 1'b0, 1'b0, B_GRA | B_ROUT | B_MDRIN, A0, 1'b1);
    row(OP_ST, 1'b0, 1'b0, 1'b0, B_WRITE, A0, 1'b1);
    row(OP_ST, 1'b1, 1'b0, 1'b0, B_WRITE, A0, 1'b1);
    // mul with stop raised in T4: full instruction, then HALT
    fetch(OP_MUL, 0, 1'b0);
    row(OP_MUL, 1'b1, 1'b0, 1'b0, B_GRA | B_ROUT | B_YIN, A0, 1'b1);
    row(OP_MUL, 1'b1, 1'b1, 1'b0, B_GRB | B_ROUT | B_ZIN, OP_MUL, 1'b1);
    row(OP_MUL, 1'b1, 1'b1, 1'b0, B_ZLOOUT | B_LOIN, A0, 1'b1);
    row(OP_MUL, 1'b1, 1'b1, 1'b0, B_ZHIOUT | B_HIIN, A0, 1'b1);
    for (int h = 0; h < 10; h++) row(OP_MUL, 1'b1, 1'b0, 1'b0, NONE, A0, 1'b0);

    // Reset state, then release so the table starts in T0
    @(negedge clock);
    #1;
    check("reset_state", {A0, 1'b1, 1'b0, NONE});
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      set_ir(tbl[i].op);
      bus_if.mem_ready = tbl[i].mem_ready;
      bus_if.stop = tbl[i].stop;
      bus_if.con_ff = tbl[i].con_ff;
      #1;
      check($sformatf("vec%0d", i), {tbl[i].alu, 1'b0, tbl[i].run, tbl[i].strb});
    end

    // Asynchronous reset in the middle of st T5
    bus_if.stop = 1'b0;
    bus_if.mem_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    set_ir(OP_ST);
    repeat (6) @(negedge clock);
    #1;
    check("st_T5", {A0, 1'b0, 1'b1, B_ZLOOUT | B_MARIN});
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_in_T5", {A0, 1'b1, 1'b0, NONE});
    @(posedge clock);
    #1;
    check("reset_held", {A0, 1'b1, 1'b0, NONE});
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("resume_T0", {A0, 1'b0, 1'b1, F0});

    // halt instruction enters HALT straight after T2
    set_ir(OP_HALT);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("halt_T2", {A0, 1'b0, 1'b1, F2});
    for (int h = 0; h < 3; h++) begin
      @(negedge clock);
      #1;
      check($sformatf("halt_hold%0d", h), {A0, 1'b0, 1'b0, NONE});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
